// File: rtl/sram_pixel_packer_if.sv
// Pixel-in / command-out bundle of the SRAM pixel packer, plus its frame handshakes.
// slave is the packer side; master is the swap controller, pixel source and arbiter side.
interface sram_pixel_packer_if #(
  parameter int ADDR_WIDTH = 18
);
  logic                  start;
  logic                  start_ack;
  logic                  done;
  logic                  done_ack;
  logic [7:0]            din;
  logic                  din_valid;
  logic                  din_ready;
  logic [ADDR_WIDTH+35:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
`ifdef PACKER_FLUSH_EN
  logic                  flush;

  modport master (
    output start, done_ack, din, din_valid, dout_ready, flush,
    input  start_ack, done, din_ready, dout, dout_valid
  );
  modport slave (
    input  start, done_ack, din, din_valid, dout_ready, flush,
    output start_ack, done, din_ready, dout, dout_valid
  );
`else
  modport master (
    output start, done_ack, din, din_valid, dout_ready,
    input  start_ack, done, din_ready, dout, dout_valid
  );
  modport slave (
    input  start, done_ack, din, din_valid, dout_ready,
    output start_ack, done, din_ready, dout, dout_valid
  );
`endif
endinterface

// File: rtl/sram_pixel_packer.sv
// Packs a frame of 8-bit pixels, four per word, into {mask, addr, data} SRAM write commands.
// Optional early partial-word flush input is enabled by PACKER_FLUSH_EN.
module sram_pixel_packer #(
  parameter int N_PIXEL    = 480000,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_WIDTH = 18
) (
  input logic                clock,
  input logic                reset,
  sram_pixel_packer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_DONE, S_ACK} state_t;

  localparam logic [19:0]           LAST_IDX = 20'(N_PIXEL - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_t                 r_state;
  state_t                 w_next;
  logic [23:0]            r_acc;
  logic [1:0]             r_bcnt;
  logic [19:0]            r_pcnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH+35:0] r_dout;
  logic                   r_dout_vld;

  logic        w_take;
  logic        w_out_free;
  logic        w_last;
  logic        w_din_ready;
  logic        w_fire;
  logic        w_word_done;
  logic        w_flush;
  logic        w_issue;
  logic        w_start_ack;
  logic        w_done;
  logic [31:0] w_data;
  logic [2:0]  w_nbytes;
  logic [4:0]  w_onehot;
  logic [3:0]  w_mask;

  assign w_take      = r_dout_vld & bus.dout_ready;
  assign w_out_free  = ~r_dout_vld | w_take;
  assign w_last      = (r_pcnt == LAST_IDX);
  // Only a pixel that completes a word needs the output register to be free.
  assign w_din_ready = (r_state == S_RUN) & ~(((r_bcnt == 2'd3) | w_last) & ~w_out_free);
  assign w_fire      = bus.din_valid & w_din_ready;
  assign w_word_done = w_fire & ((r_bcnt == 2'd3) | w_last);

`ifdef PACKER_FLUSH_EN
  // A flush arriving while the previous word is still held is dropped.
  assign w_flush = bus.flush & (r_state == S_RUN) & w_out_free & ((r_bcnt != 2'd0) | w_fire);
`else
  assign w_flush = 1'b0;
`endif

  assign w_issue  = w_word_done | w_flush;
  assign w_nbytes = {1'b0, r_bcnt} + {2'b00, w_fire};
  assign w_onehot = 5'd1 << w_nbytes;
  assign w_mask   = w_onehot[3:0] - 4'd1;

  always_comb begin
    w_data = {8'h00, r_acc};
    if (w_fire) w_data = w_data | ({24'h000000, bus.din} << {r_bcnt, 3'b000});
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_start_ack = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE:  if (bus.start) w_next = S_START;
      S_START: begin
        w_start_ack = 1'b1;
        if (!bus.start) w_next = S_RUN;
      end
      S_RUN:   if (w_fire && w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_take) w_next = S_DONE;
      S_DONE:  begin
        w_done = 1'b1;
        if (bus.done_ack) w_next = S_ACK;
      end
      S_ACK:   if (!bus.done_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc      <= '0;
      r_bcnt     <= '0;
      r_pcnt     <= '0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      if (w_take) r_dout_vld <= 1'b0;
      if (r_state == S_IDLE) begin
        r_acc  <= '0;
        r_bcnt <= '0;
        r_pcnt <= '0;
        r_addr <= BASE;
      end
      if (w_fire) r_pcnt <= r_pcnt + 20'd1;
      // A new word may load in the same cycle the held one is taken.
      if (w_issue) begin
        r_dout     <= {w_mask, r_addr, w_data};
        r_dout_vld <= 1'b1;
        r_addr     <= r_addr + ADDR_WIDTH'(1);
        r_acc      <= '0;
        r_bcnt     <= '0;
      end else if (w_fire) begin
        r_acc  <= w_data[23:0];
        r_bcnt <= r_bcnt + 2'd1;
      end
    end
  end

  assign bus.start_ack  = w_start_ack;
  assign bus.done       = w_done;
  assign bus.din_ready  = w_din_ready;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_vld;
endmodule
